// File: rtl/shift_pkg.sv
// +----------------------------------------------------------------------+
// | shift_pkg : shared state and operation encodings for the shift units |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROL = 2'd3
  } shift_op_e;

  // Width of a counter that indexes LOG2N barrel levels (at least one bit).
  function automatic int lvl_bits(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shl_level.sv
// +----------------------------------------------------------------------+
// | shl_level : one barrel level, acc << (1<<lvl) plus lost-bit OR       |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module shl_level #(
  parameter int N   = 8,
  parameter int LOG = 3,
  parameter int LVW = 2
) (
  input  logic [N-1:0]   acc_i,
  input  logic [LVW-1:0] lvl_i,
  input  logic           en_i,
  output logic [N-1:0]   acc_o,
  output logic           disc_o
);

  localparam int NSEL = 1 << LVW;

  logic [N-1:0]    w_shift [NSEL];
  logic [NSEL-1:0] w_disc;

  // Unused selector slots (LOG not a power of two) are tied off.
  for (genvar gi = 0; gi < NSEL; gi++) begin : g_lvl
    if (gi < LOG) begin : g_real
      localparam int K = 1 << gi;
      assign w_shift[gi] = acc_i << K;
      assign w_disc[gi]  = |acc_i[N-1 -: K];
    end else begin : g_pad
      assign w_shift[gi] = '0;
      assign w_disc[gi]  = 1'b0;
    end
  end

  assign acc_o  = en_i ? w_shift[lvl_i] : acc_i;
  assign disc_o = en_i & w_disc[lvl_i];

endmodule

`default_nettype wire

// File: rtl/shift_left_seq.sv
// +----------------------------------------------------------------------+
// | shift_left_seq : sequential logical left shift, one level per cycle  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_left_seq
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int LOG = $clog2(N);
  localparam int LVW = lvl_bits(LOG);

  shift_state_e   state_q;
  logic [N-1:0]   acc_q;
  logic [N-1:0]   amt_q;
  logic [LVW-1:0] lvl_q;
  logic           ovf_acc_q;
  logic [N-1:0]   out_q;
  logic           ovf_q;
  logic           busy_q;
  logic           done_q;

  logic [N-1:0]   acc_d;
  logic           w_disc;
  logic           ovf_acc_d;
  logic           w_big;

  shl_level #(
    .N   (N),
    .LOG (LOG),
    .LVW (LVW)
  ) u_level (
    .acc_i  (acc_q),
    .lvl_i  (lvl_q),
    .en_i   (amt_q[lvl_q]),
    .acc_o  (acc_d),
    .disc_o (w_disc)
  );

  assign ovf_acc_d = ovf_acc_q | w_disc;
  assign w_big     = |amt_q[N-1:LOG];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      amt_q     <= '0;
      lvl_q     <= '0;
      ovf_acc_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            acc_q     <= a;
            amt_q     <= b;
            lvl_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q     <= acc_d;
          ovf_acc_q <= ovf_acc_d;
          lvl_q     <= lvl_q + LVW'(1);
          if (lvl_q == LVW'(LOG - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Every bit of a is either lost or still in acc, so this ORs all of a.
            out_q   <= w_big ? '0 : acc_d;
            ovf_q   <= w_big ? (ovf_acc_d | (|acc_d)) : ovf_acc_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_left_seq.sv
// +----------------------------------------------------------------------+
// | tb_shift_left_seq : scoreboard bench with random and directed ops    |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_shift_left_seq;

  localparam int N   = 8;
  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] out;
  logic         ovf;
  logic         busy;
  logic         done;

  shift_left_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [N-1:0] o;
    logic         v;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   armed = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] ref_out(input logic [N-1:0] x, input logic [N-1:0] s);
    if (s >= N) return '0;
    return N'(x << s);
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] s);
    if (s == 0)  return 1'b0;
    if (s >= N)  return x != 0;
    return (x >> (N - s)) != 0;
  endfunction

  // Waits for the DUT to be able to accept, then drives one request.
  task automatic issue(input logic [N-1:0] xa, input logic [N-1:0] xb, input bit keep);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: busy stuck at %b", busy);
      return;
    end
    start = 1'b1;
    a     = xa;
    b     = xb;
    q.push_back('{o: ref_out(xa, xb), v: ref_ovf(xa, xb), acc: cyc + 1});
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (armed && rst === 1'b0) begin
      exp_t e;
      logic bexp;
      bexp = (q.size() != 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + LAT);
      chk("busy", busy, bexp);
      if (done === 1'b1 && prev_done === 1'b1) chk("done_width", 2, 1);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out", out, e.o);
          chk("ovf", ovf, e.v);
          chk("latency", cyc, e.acc + LAT);
        end
      end
    end
    prev_done <= done;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst   = 1'b0;
    armed = 1;
    @(negedge clk);

    issue(8'b1011_0001, 8'd3, 0);
    drain();
    issue(8'h0F, 8'd4, 0);
    issue(8'h5A, 8'd0, 0);
    drain();
    issue(8'h01, 8'd9, 0);
    issue(8'h00, 8'hFF, 0);
    drain();

    // Second start while shifting must be ignored.
    issue(8'h03, 8'd1, 0);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'd7;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Reset one cycle into the shift aborts the operation.
    issue(8'hC3, 8'd2, 0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_out", out, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(8'h81, 8'd1, 0);
    drain();

    // Start held high across several operations.
    issue(8'h11, 8'd2, 1);
    issue(8'h80, 8'd1, 1);
    issue(8'h7E, 8'd5, 1);
    issue(8'hAA, 8'd0, 0);
    drain();

    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, N - 1));
      issue(ra, rb, $urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 SHALL have parameter N, default 8, operand/result width in bits (power of two, >= 4).
REQ-002 SHALL have derived constant LOG = $clog2(N), the number of shift levels and the operation latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a shift; sampled only in IDLE or DONE.
REQ-006 SHALL have port a, input, N bits: operand, captured on the accepting edge.
REQ-007 SHALL have port b, input, N bits: unsigned shift amount, captured on the accepting edge.
REQ-008 SHALL have port out, output, N bits: result of logical left shift a << b, zero-filled from bit 0.
REQ-009 SHALL have port ovf, output, 1 bit: high if any 1 bit of a was shifted out past bit N-1.
REQ-010 SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when out/ovf become valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, capture a into accumulator acc and b into amt, clear level counter lvl and ovf accumulator, and enter SHIFT.
REQ-014 SHALL, in SHIFT, apply one barrel level per cycle: if amt[lvl]=1, acc <= acc << (1<<lvl) with zero fill, and OR the discarded top (1<<lvl) bits into the ovf accumulator; lvl increments each cycle.
REQ-015 SHALL, on the edge completing level LOG-1, load out and ovf, assert done for exactly one cycle, and enter DONE.
REQ-016 SHALL, when any bit of amt[N-1:LOG] is 1 (shift >= N), produce out=0 and ovf=|a, with unchanged latency.
REQ-017 SHALL have fixed latency: done high in the cycle after the LOG-th edge following the accepting edge, independent of b (b=0 included).
REQ-018 SHALL ignore start while in SHIFT; captured operands, out and ovf are not disturbed.
REQ-019 SHALL hold out and ovf stable from done until the next accepted operation completes; busy=0 in IDLE and DONE.
REQ-020 SHALL accept start in DONE on the cycle done is high, giving back-to-back operations with no idle cycle.
REQ-021 SHALL remain in DONE, or in IDLE, while start=0.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, enter IDLE and set out=0, ovf=0, busy=0, done=0, lvl=0, acc=0, amt=0.
REQ-023 SHALL give rst priority over start and abort an in-flight SHIFT, producing no done pulse for the aborted operation.

Structure
REQ-024 SHALL take the state enum type (IDLE/SHIFT/DONE) from shared package shift_pkg, alongside the encodings used by the other shift units.
REQ-025 SHALL place one shift level (N-bit 2:1 mux selection between acc and acc << k, plus discarded-bit OR) in sub-module shl_level, instantiated once and driven by lvl.

Verification (N=8, LOG=3)
REQ-026 SHALL test a=8'b1011_0001, b=3 -> out=8'b1000_1000, ovf=1, done 3 cycles after the accepting edge, busy high for 3 cycles.
REQ-027 SHALL test a=8'h0F, b=4 -> out=8'hF0, ovf=0; then a=8'h5A, b=0 -> out=8'h5A, ovf=0, same latency.
REQ-028 SHALL test a=8'h01, b=9 -> out=8'h00, ovf=1; and a=8'h00, b=8'hFF -> out=8'h00, ovf=0.
REQ-029 SHALL test a=8'h03, b=1, then start with a=8'hFF, b=7 pulsed during SHIFT -> ignored, out=8'h06, ovf=0, single done.
REQ-030 SHALL test rst asserted one cycle into SHIFT -> next cycle out=0, ovf=0, busy=0, done never pulses; a new start completes normally.
REQ-031 SHALL test start held high in DONE -> back-to-back results, each done exactly one cycle wide and 3 cycles after its accepting edge.
